// File: rtl/float_op_dispatcher_if.sv
// float_op_dispatcher_if
// Groups the producer handshake and the adder launch/completion signals of
// the float_op_dispatcher into a single bundle.
//   in_valid/in_ready/in_op/in_A/in_B : producer side, one operation per handshake
//   out_start/out_op/out_A/out_B      : launch pulse and operands to the adder
//   adder_done                        : completion pulse from the adder
// Modports:
//   master : producer/adder environment (drives requests and adder_done)
//   slave  : the dispatcher itself
interface float_op_dispatcher_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_op;
  logic [31:0] in_A;
  logic [31:0] in_B;
  logic        out_start;
  logic        out_op;
  logic [31:0] out_A;
  logic [31:0] out_B;
  logic        adder_done;

  modport master (
    output in_valid, in_op, in_A, in_B, adder_done,
    input  in_ready, out_start, out_op, out_A, out_B
  );

  modport slave (
    input  in_valid, in_op, in_A, in_B, adder_done,
    output in_ready, out_start, out_op, out_A, out_B
  );
endinterface

// File: rtl/float_op_dispatcher.sv
// float_op_dispatcher
// Buffers add/subtract requests in a DEPTH-entry FIFO and launches them one at
// a time into a floating-point adder, waiting for the adder's completion pulse
// before launching the next one.
// Ports:
//   clk        : sole clock, rising edge
//   reset      : synchronous, active-low
//   bus        : float_op_dispatcher_if.slave (producer handshake + adder link)
//   busy       : an operation is being launched or is in flight
//   count      : FIFO occupancy
//   done_count : completed operations, wraps 255 -> 0
//   timeout    : sticky watchdog flag
// Parameters:
//   DEPTH          : FIFO depth, power of two, 2..16
//   TIMEOUT_CYCLES : watchdog limit in WAIT cycles
// Optional feature: define FLOAT_DISPATCH_TIMEOUT_EN to build the watchdog.
// Without it, timeout is tied to 0 and WAIT lasts until adder_done.
module float_op_dispatcher #(
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  float_op_dispatcher_if.slave     bus,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   count,
  output logic [7:0]               done_count,
  output logic                     timeout
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t state;
  state_t state_next;

  logic              op_mem [DEPTH];
  logic [31:0]       a_mem  [DEPTH];
  logic [31:0]       b_mem  [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  logic        push;
  logic        pop;
  logic        load;
  logic        done_accept;
  logic        timeout_hit;
  logic        out_op_r;
  logic [31:0] out_a_r;
  logic [31:0] out_b_r;

  assign bus.in_ready  = (count < CNT_W'(DEPTH));
  assign push          = bus.in_valid && bus.in_ready;
  assign bus.out_start = (state == ISSUE);
  assign busy          = (state != IDLE);
  assign bus.out_op    = out_op_r;
  assign bus.out_A     = out_a_r;
  assign bus.out_B     = out_b_r;

  // The head is copied to the outputs on the IDLE->ISSUE edge so the operands
  // are already valid while out_start is high; the entry itself is retired
  // at the end of the ISSUE cycle.
  assign load = (state == IDLE) && (count != '0);

  always_comb begin
    state_next  = state;
    pop         = 1'b0;
    done_accept = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) state_next = ISSUE;
      end
      ISSUE: begin
        pop        = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        // A completion in the same cycle as the watchdog limit still counts.
        if (bus.adder_done) begin
          done_accept = 1'b1;
          state_next  = IDLE;
        end else if (timeout_hit) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Storage has no reset: occupancy and pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      op_mem[wr_ptr] <= bus.in_op;
      a_mem[wr_ptr]  <= bus.in_A;
      b_mem[wr_ptr]  <= bus.in_B;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      done_count <= '0;
      out_op_r   <= 1'b0;
      out_a_r    <= '0;
      out_b_r    <= '0;
    end else begin
      state <= state_next;
      // Pointers are exactly PTR_W bits wide, so they wrap modulo DEPTH.
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (load) begin
        out_op_r <= op_mem[rd_ptr];
        out_a_r  <= a_mem[rd_ptr];
        out_b_r  <= b_mem[rd_ptr];
      end
      if (done_accept) done_count <= done_count + 8'd1;
    end
  end

`ifdef FLOAT_DISPATCH_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_count;
  logic            timeout_r;

  // wd_count holds the number of WAIT cycles already spent without a
  // completion, so the limit is reached on the TIMEOUT_CYCLES-th one.
  assign timeout_hit = (state == WAIT) && (wd_count == WD_W'(TIMEOUT_CYCLES - 1));
  assign timeout     = timeout_r;

  always_ff @(posedge clk) begin
    if (!reset) begin
      wd_count  <= '0;
      timeout_r <= 1'b0;
    end else if (state == ISSUE) begin
      wd_count <= '0;
    end else if ((state == WAIT) && !bus.adder_done) begin
      if (timeout_hit) timeout_r <= 1'b1;
      else             wd_count  <= wd_count + WD_W'(1);
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign timeout     = 1'b0;
`endif

endmodule

// File: tb/tb_float_op_dispatcher.sv
// tb_float_op_dispatcher
// Self-checking bench for float_op_dispatcher. A transaction-level model
// (a queue of pending operations plus launch/in-flight flags) predicts every
// output after every clock edge; directed steps cover single-op latency,
// filling, simultaneous push/pop, reset in flight, done_count wrap and the
// watchdog (FLOAT_DISPATCH_TIMEOUT_EN when defined).
module tb_float_op_dispatcher;

  localparam int DEPTH = 4;
  localparam int TMO   = 64;

  typedef struct packed {
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
  } entry_t;

  logic       clk;
  logic       reset;
  logic       busy;
  logic [2:0] count;
  logic [7:0] done_count;
  logic       timeout;

  float_op_dispatcher_if dif();

  float_op_dispatcher #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (dif),
    .busy       (busy),
    .count      (count),
    .done_count (done_count),
    .timeout    (timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model state
  entry_t     q[$];
  bit         m_launch;
  bit         m_wait;
  int         m_wcnt;
  entry_t     m_out;
  logic [7:0] m_done;
  bit         m_timeout;
  int         completions;

  int total;
  int bad;

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    cmp("in_ready",   {31'd0, dif.in_ready},  {31'd0, (q.size() < DEPTH)});
    cmp("count",      {29'd0, count},         q.size());
    cmp("out_start",  {31'd0, dif.out_start}, {31'd0, m_launch});
    cmp("busy",       {31'd0, busy},          {31'd0, (m_launch || m_wait)});
    cmp("done_count", {24'd0, done_count},    {24'd0, m_done});
    cmp("timeout",    {31'd0, timeout},       {31'd0, m_timeout});
    cmp("out_op",     {31'd0, dif.out_op},    {31'd0, m_out.op});
    cmp("out_A",      dif.out_A,              m_out.a);
    cmp("out_B",      dif.out_B,              m_out.b);
  endtask

  // Drives one cycle of inputs, advances the model across the edge, checks.
  task automatic applyStimulus(input bit rst_n, input bit v, input bit op,
                               input logic [31:0] a, input logic [31:0] b,
                               input bit done);
    bit     accept;
    entry_t e;
    reset          = rst_n;
    dif.in_valid   = v;
    dif.in_op      = op;
    dif.in_A       = a;
    dif.in_B       = b;
    dif.adder_done = done;
    @(posedge clk);
    if (!rst_n) begin
      q.delete();
      m_launch  = 0;
      m_wait    = 0;
      m_wcnt    = 0;
      m_out     = '0;
      m_done    = '0;
      m_timeout = 0;
    end else begin
      accept = v && (q.size() < DEPTH);
      if (m_launch) begin
        e        = q.pop_front();
        m_launch = 0;
        m_wait   = 1;
        m_wcnt   = 0;
      end else if (m_wait) begin
        if (done) begin
          m_wait = 0;
          m_done = m_done + 8'd1;
          completions++;
        end else begin
          m_wcnt++;
`ifdef FLOAT_DISPATCH_TIMEOUT_EN
          if (m_wcnt == TMO) begin
            m_wait    = 0;
            m_timeout = 1;
          end
`endif
        end
      end else if (q.size() > 0) begin
        m_launch = 1;
        m_out    = q[0];
      end
      if (accept) q.push_back('{op: op, a: a, b: b});
    end
    #1;
    checkOutput();
  endtask

  task automatic idle(input bit done);
    applyStimulus(1, 0, 0, 32'd0, 32'd0, done);
  endtask

  task automatic pushRandom();
    applyStimulus(1, 1, 1'($urandom), $urandom, $urandom, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && (q.size() > 0 || m_launch || m_wait); i++) idle(m_wait);
    cmp("drain_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    completions = 0;
    m_out = '0;
    m_done = '0;

    // Reset state and first cycle after release
    applyStimulus(0, 0, 0, 32'd0, 32'd0, 0);
    applyStimulus(0, 1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    idle(0);
    cmp("ready_after_reset", {31'd0, dif.in_ready}, 32'd1);

    // Single op: launch two edges after the push, operands as pushed
    applyStimulus(1, 1, 0, 32'h4000_000F, 32'hC000_0007, 0);
    cmp("single_no_start_yet", {31'd0, dif.out_start}, 32'd0);
    idle(0);
    cmp("single_start", {31'd0, dif.out_start}, 32'd1);
    cmp("single_A", dif.out_A, 32'h4000_000F);
    cmp("single_B", dif.out_B, 32'hC000_0007);
    idle(1);
    idle(1);
    cmp("single_done", {24'd0, done_count}, 32'd1);
    cmp("single_idle", {31'd0, busy}, 32'd0);

    // Fill: back-to-back pushes with the adder stalled
    for (int i = 0; i < 5; i++) pushRandom();
    cmp("fill_count", {29'd0, count}, 32'd4);
    cmp("fill_ready", {31'd0, dif.in_ready}, 32'd0);
    pushRandom();
    pushRandom();
    drain();

    // Push in the ISSUE cycle at count=2
    pushRandom();
    pushRandom();
    cmp("pp_start", {31'd0, dif.out_start}, 32'd1);
    cmp("pp_count_before", {29'd0, count}, 32'd2);
    pushRandom();
    cmp("pp_count_after", {29'd0, count}, 32'd2);
    drain();

    // Reset while an operation is in flight
    pushRandom();
    pushRandom();
    for (int i = 0; i < 10 && !m_wait; i++) idle(0);
    cmp("rst_in_wait", {31'd0, busy}, 32'd1);
    applyStimulus(0, 0, 0, 32'd0, 32'd0, 0);
    idle(1);
    cmp("rst_count", {29'd0, count}, 32'd0);
    cmp("rst_busy", {31'd0, busy}, 32'd0);
    cmp("rst_done", {24'd0, done_count}, 32'd0);

    // 256 completions under random traffic: done_count wraps, pointers wrap
    completions = 0;
    for (int i = 0; i < 6000 && completions < 256; i++) begin
      applyStimulus(1, 1'($urandom_range(0, 1)), 1'($urandom), $urandom, $urandom,
                    m_wait ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0));
    end
    cmp("wrap_completions", completions, 32'd256);
    cmp("wrap_done_count", {24'd0, done_count}, 32'd0);
    drain();

    // Watchdog: adder never answers
    applyStimulus(0, 0, 0, 32'd0, 32'd0, 0);
    pushRandom();
    pushRandom();
    for (int i = 0; i < TMO + 6; i++) idle(0);
`ifdef FLOAT_DISPATCH_TIMEOUT_EN
    cmp("wd_timeout", {31'd0, timeout}, 32'd1);
    cmp("wd_done", {24'd0, done_count}, 32'd0);
    cmp("wd_second_issued", {29'd0, count}, 32'd0);
`else
    cmp("wd_timeout", {31'd0, timeout}, 32'd0);
    cmp("wd_still_busy", {31'd0, busy}, 32'd1);
    cmp("wd_pending", {29'd0, count}, 32'd1);
`endif
    idle(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
